// File: rtl/sram_bus_master.sv
// Initiator for the synchronous single-port SRAM bus: valid/ready request in, read data out.
// Define SRAM_MASTER_SKID_EN to add a one-entry request skid register for back-to-back issue.
module sram_bus_master #(
  parameter int unsigned ADDR_WIDTH   = 30,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam int unsigned CNT_W = 3;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  drive;

  logic                  accept;
  logic                  done;
  logic                  start;
  logic                  start_we;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [DATA_WIDTH-1:0] start_wdata;

`ifdef SRAM_MASTER_SKID_EN
  logic                  skid_valid;
  logic                  skid_we;
  logic [ADDR_WIDTH-1:0] skid_addr;
  logic [DATA_WIDTH-1:0] skid_wdata;
  logic                  push;
`endif

  // Only the WRITE state ever drives the shared data bus.
  assign mem_data = drive ? wdata : {DATA_WIDTH{1'bz}};

  // Select which request (if any) launches on this edge.
  always_comb begin
    accept      = req_valid && req_ready;
    done        = (state == WRITE) || ((state == RESP) && rsp_valid && rsp_ready);
    start       = 1'b0;
    start_we    = req_we;
    start_addr  = req_addr;
    start_wdata = req_wdata;
`ifdef SRAM_MASTER_SKID_EN
    push = 1'b0;
    if (state == IDLE) begin
      start = accept;
    end else if (done && skid_valid) begin
      start       = 1'b1;
      start_we    = skid_we;
      start_addr  = skid_addr;
      start_wdata = skid_wdata;
    end else if (done) begin
      start = accept;
    end else begin
      push = accept;
    end
`else
    start = accept && (state == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wdata     <= '0;
      drive     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
`ifdef SRAM_MASTER_SKID_EN
      skid_valid <= 1'b0;
      skid_we    <= 1'b0;
      skid_addr  <= '0;
      skid_wdata <= '0;
`endif
    end else begin
      if (state == READ) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(READ_LATENCY)) begin
          rsp_rdata <= mem_data;
          rsp_valid <= 1'b1;
          state     <= RESP;
          mem_cs    <= 1'b0;
          mem_oe    <= 1'b0;
        end
      end
      if (done) begin
        state     <= IDLE;
        rsp_valid <= 1'b0;
        mem_cs    <= 1'b0;
        mem_we    <= 1'b0;
        drive     <= 1'b0;
        busy      <= 1'b0;
        req_ready <= 1'b1;
      end
      // A launch overrides the return to IDLE taken on a completion edge.
      if (start) begin
        state     <= start_we ? WRITE : READ;
        cnt       <= '0;
        mem_addr  <= start_addr;
        wdata     <= start_wdata;
        mem_cs    <= 1'b1;
        mem_we    <= start_we;
        mem_oe    <= !start_we;
        drive     <= start_we;
        busy      <= 1'b1;
        req_ready <= 1'b0;
      end
`ifdef SRAM_MASTER_SKID_EN
      if (push) begin
        skid_valid <= 1'b1;
        skid_we    <= req_we;
        skid_addr  <= req_addr;
        skid_wdata <= req_wdata;
      end else if (done && skid_valid) begin
        skid_valid <= 1'b0;
      end
      req_ready <= !(push || (skid_valid && !done));
`endif
    end
  end

endmodule
